// File: rtl/pipeline_pkg.sv
// Shared encodings and default timing constants for the 5-stage MIPS pipeline control.
package pipeline_pkg;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    localparam logic [1:0] MEMREAD_NONE = 2'b00;

    localparam int MUL_CYCLES_DEF = 4;
    localparam int DIV_CYCLES_DEF = 32;
    localparam int CNT_W_DEF      = 6;

endpackage

// File: rtl/md_timer.sv
// Mult/div occupancy timer: holds the pipeline frozen while the multi-cycle
// unit owns EXE and pulses md_done in its final cycle.
module md_timer
    import pipeline_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic md_start_exe,
    input  logic md_is_div_exe,
    input  logic exc_mem,
    output logic freeze,
    output logic md_done
);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    md_state_e        state;
    md_state_e        state_next;
    logic [CNT_W-1:0] md_cnt;
    logic [CNT_W-1:0] md_cnt_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= MD_IDLE;
            md_cnt <= '0;
        end else begin
            state  <= state_next;
            md_cnt <= md_cnt_next;
        end
    end

    always_comb begin
        state_next  = state;
        md_cnt_next = md_cnt;
        freeze      = 1'b0;
        md_done     = 1'b0;
        if (exc_mem) begin
            // An exception in MEM abandons any in-flight mult/div silently.
            state_next  = MD_IDLE;
            md_cnt_next = '0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (md_start_exe) begin
                        freeze      = 1'b1;
                        md_cnt_next = md_is_div_exe ? DIV_LOAD : MUL_LOAD;
                        state_next  = MD_BUSY;
                    end
                end
                MD_BUSY: begin
                    if (md_cnt > CNT_ONE) begin
                        freeze      = 1'b1;
                        md_cnt_next = md_cnt - CNT_ONE;
                    end else begin
                        md_done     = 1'b1;
                        md_cnt_next = '0;
                        state_next  = MD_IDLE;
                    end
                end
                default: begin
                    state_next  = MD_IDLE;
                    md_cnt_next = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: per-stage stall/flush enables from exception,
// mult/div freeze, load-use interlock and taken-branch squash, plus a stall counter.
module hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs_id,
    input  logic [4:0]  rt_id,
    input  logic        use_rs_id,
    input  logic        use_rt_id,
    input  logic [4:0]  rd_exe,
    input  logic        RegWrite_exe,
    input  logic [1:0]  MemRead_exe,
    input  logic        branch_taken_id,
    input  logic        md_start_exe,
    input  logic        md_is_div_exe,
    input  logic        exc_mem,
    output logic        stall_pc,
    output logic        stall_if_id,
    output logic        stall_id_exe,
    output logic        stall_exe_mem,
    output logic        flush_if_id,
    output logic        flush_id_exe,
    output logic        flush_exe_mem,
    output logic        md_done,
    output logic [31:0] stall_count
);

    logic freeze;
    logic md_done_raw;
    logic load_use;

    md_timer #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) u_md (
        .clk           (clk),
        .rst           (rst),
        .md_start_exe  (md_start_exe),
        .md_is_div_exe (md_is_div_exe),
        .exc_mem       (exc_mem),
        .freeze        (freeze),
        .md_done       (md_done_raw)
    );

    // Only a load still in EXE needs a bubble; everything else is forwarded in ID.
    assign load_use = (MemRead_exe != MEMREAD_NONE) && RegWrite_exe && (rd_exe != 5'd0) &&
                      ((use_rs_id && (rs_id == rd_exe)) || (use_rt_id && (rt_id == rd_exe)));

    assign md_done = md_done_raw & ~rst;

    always_comb begin
        stall_pc      = 1'b0;
        stall_if_id   = 1'b0;
        stall_id_exe  = 1'b0;
        stall_exe_mem = 1'b0;
        flush_if_id   = 1'b0;
        flush_id_exe  = 1'b0;
        flush_exe_mem = 1'b0;
        if (rst || exc_mem) begin
            flush_if_id   = 1'b1;
            flush_id_exe  = 1'b1;
            flush_exe_mem = 1'b1;
        end else if (freeze) begin
            stall_pc      = 1'b1;
            stall_if_id   = 1'b1;
            stall_id_exe  = 1'b1;
            stall_exe_mem = 1'b1;
            flush_exe_mem = 1'b1;
        end else if (load_use) begin
            stall_pc      = 1'b1;
            stall_if_id   = 1'b1;
            flush_id_exe  = 1'b1;
        end else if (branch_taken_id) begin
            flush_if_id   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
        end else if (stall_pc) begin
            stall_count <= stall_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a queue-based scoreboard of expected control vectors.
module tb_hazard_ctrl;
    import pipeline_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs_id, rt_id, rd_exe;
    logic        use_rs_id, use_rt_id, RegWrite_exe;
    logic [1:0]  MemRead_exe;
    logic        branch_taken_id, md_start_exe, md_is_div_exe, exc_mem;
    logic        stall_pc, stall_if_id, stall_id_exe, stall_exe_mem;
    logic        flush_if_id, flush_id_exe, flush_exe_mem, md_done;
    logic [31:0] stall_count;

    int errors = 0;
    int checks = 0;

    // {stall_pc, stall_if_id, stall_id_exe, stall_exe_mem, flush_if_id, flush_id_exe, flush_exe_mem, md_done}
    localparam logic [7:0] V_NONE = 8'b0000_0000;
    localparam logic [7:0] V_FRZ  = 8'b1111_0010;
    localparam logic [7:0] V_LU   = 8'b1100_0100;
    localparam logic [7:0] V_BR   = 8'b0000_1000;
    localparam logic [7:0] V_FL   = 8'b0000_1110;
    localparam logic [7:0] V_DONE = 8'b0000_0001;

    logic [7:0] exp_q[$];

    hazard_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .rs_id           (rs_id),
        .rt_id           (rt_id),
        .use_rs_id       (use_rs_id),
        .use_rt_id       (use_rt_id),
        .rd_exe          (rd_exe),
        .RegWrite_exe    (RegWrite_exe),
        .MemRead_exe     (MemRead_exe),
        .branch_taken_id (branch_taken_id),
        .md_start_exe    (md_start_exe),
        .md_is_div_exe   (md_is_div_exe),
        .exc_mem         (exc_mem),
        .stall_pc        (stall_pc),
        .stall_if_id     (stall_if_id),
        .stall_id_exe    (stall_id_exe),
        .stall_exe_mem   (stall_exe_mem),
        .flush_if_id     (flush_if_id),
        .flush_id_exe    (flush_id_exe),
        .flush_exe_mem   (flush_exe_mem),
        .md_done         (md_done),
        .stall_count     (stall_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed running required finished");
        $fatal(1, "timeout");
    end

    task automatic clear_inputs();
        rs_id = 5'd0; rt_id = 5'd0; rd_exe = 5'd0;
        use_rs_id = 1'b0; use_rt_id = 1'b0; RegWrite_exe = 1'b0;
        MemRead_exe = 2'b00; branch_taken_id = 1'b0;
        md_start_exe = 1'b0; md_is_div_exe = 1'b0; exc_mem = 1'b0;
    endtask

    task automatic set_load_use(input logic [4:0] r);
        MemRead_exe = 2'b01; RegWrite_exe = 1'b1; rd_exe = r;
        rs_id = r; use_rs_id = 1'b1;
    endtask

    // Called just after a rising edge: scores the combinational outputs, then advances one cycle.
    task automatic step(input logic [7:0] exp, input string tag);
        logic [7:0] obs;
        logic [7:0] want;
        exp_q.push_back(exp);
        #2;
        obs  = {stall_pc, stall_if_id, stall_id_exe, stall_exe_mem,
                flush_if_id, flush_id_exe, flush_exe_mem, md_done};
        want = exp_q.pop_front();
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, want);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk32(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        step(V_FL, "reset_outputs");
        chk32(32'(dut.u_md.state), 32'(MD_IDLE), "reset_state");
        chk32(32'(dut.u_md.md_cnt), 32'd0, "reset_md_cnt");
        chk32(stall_count, 32'd0, "reset_stall_count");
        rst = 1'b0;

        step(V_NONE, "idle");

        // Load-use on rs
        set_load_use(5'd8);
        step(V_LU, "load_use_rs");
        chk32(stall_count, 32'd1, "count_after_lu");
        clear_inputs();
        step(V_NONE, "after_lu");

        // Destination r0 never interlocks
        set_load_use(5'd0);
        step(V_NONE, "load_use_r0");
        chk32(stall_count, 32'd1, "count_r0");

        // rt match, then unused rt
        clear_inputs();
        MemRead_exe = 2'b10; RegWrite_exe = 1'b1; rd_exe = 5'd5; rt_id = 5'd5; use_rt_id = 1'b1;
        step(V_LU, "load_use_rt");
        use_rt_id = 1'b0;
        step(V_NONE, "rt_not_used");
        RegWrite_exe = 1'b0; use_rt_id = 1'b1;
        step(V_NONE, "no_regwrite");
        chk32(stall_count, 32'd2, "count_rt");

        // Branch alone, then branch with load-use
        clear_inputs();
        branch_taken_id = 1'b1;
        step(V_BR, "branch_only");
        set_load_use(5'd9);
        step(V_LU, "branch_with_lu");
        chk32(stall_count, 32'd3, "count_branch_lu");

        // Multiply: frozen t..t+2, done at t+3; pending load-use released at t+3
        clear_inputs();
        md_start_exe = 1'b1;
        step(V_FRZ, "mul_t0");
        step(V_FRZ, "mul_t1");
        set_load_use(5'd12);
        step(V_FRZ, "mul_t2_lu_held");
        step(V_LU | V_DONE, "mul_t3_done_lu");
        clear_inputs();
        step(V_NONE, "mul_after");
        chk32(stall_count, 32'd7, "count_mul");
        chk32(32'(dut.u_md.state), 32'(MD_IDLE), "mul_idle");

        // Divide aborted by exception at t+10
        md_start_exe = 1'b1; md_is_div_exe = 1'b1;
        step(V_FRZ, "div_t0");
        md_start_exe = 1'b0;
        for (int i = 1; i <= 9; i++) step(V_FRZ, "div_busy");
        exc_mem = 1'b1;
        step(V_FL, "div_exc");
        chk32(32'(dut.u_md.state), 32'(MD_IDLE), "exc_state");
        chk32(32'(dut.u_md.md_cnt), 32'd0, "exc_md_cnt");
        exc_mem = 1'b0;
        step(V_NONE, "exc_no_done");
        step(V_NONE, "exc_no_done2");
        chk32(stall_count, 32'd17, "count_div_exc");

        // Exception while idle blocks a mult/div start
        md_start_exe = 1'b1; exc_mem = 1'b1;
        step(V_FL, "exc_blocks_start");
        chk32(32'(dut.u_md.state), 32'(MD_IDLE), "exc_start_state");
        clear_inputs();

        // Reset mid-divide at md_cnt == 20
        md_start_exe = 1'b1; md_is_div_exe = 1'b1;
        step(V_FRZ, "div2_t0");
        clear_inputs();
        for (int i = 1; i <= 11; i++) step(V_FRZ, "div2_busy");
        chk32(32'(dut.u_md.md_cnt), 32'd20, "div2_md_cnt");
        rst = 1'b1;
        step(V_FL, "rst_mid_div");
        chk32(32'(dut.u_md.state), 32'(MD_IDLE), "rst_state");
        chk32(32'(dut.u_md.md_cnt), 32'd0, "rst_md_cnt");
        chk32(stall_count, 32'd0, "rst_stall_count");
        step(V_FL, "rst_held");
        rst = 1'b0;
        step(V_NONE, "rst_released");

        // Stall counter wraps
        force dut.stall_count = 32'hFFFF_FFFF;
        #1;
        release dut.stall_count;
        set_load_use(5'd3);
        step(V_LU, "wrap_lu");
        chk32(stall_count, 32'd0, "count_wrap");
        clear_inputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
